inst_encoder_loader: RTL and testbench

- Writer side of the instruction word format consumed by the pipeline's control decoder.
- Accepts symbolic instruction commands over a valid/ready handshake and encodes each into a 32-bit MIPS word.
- Writes the words sequentially into instruction memory, then pads with NOPs so the pipeline can drain.
- Used by benches and the boot path to load programs before the core is released.

---
 rtl/inst_encoder_loader.sv | 151 +++++++++++++++
 tb/tb_inst_encoder_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - encodes symbolic commands into MIPS words and streams them into instruction memory
module inst_encoder_loader #(
    parameter int          ADDR_W   = 8,
    parameter int unsigned PAD_NOPS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PAD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [31:0]       pad_cnt_q, pad_cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        enc_valid;
    logic        full;
    logic        accept;

    // Pointer never exceeds DEPTH, so its top bit alone marks a full memory.
    assign full   = ptr_q[ADDR_W];
    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        enc_word  = 32'h0;
        enc_valid = 1'b1;
        case (cmd_op)
            4'd0:    enc_word = 32'h0;
            4'd1:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100000};
            4'd2:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100010};
            4'd3:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100100};
            4'd4:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100101};
            4'd5:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b101010};
            4'd6:    enc_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            4'd7:    enc_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            4'd8:    enc_word = {6'b000010, cmd_target};
            4'd9:    enc_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
            4'd10:   enc_word = {6'b000101, cmd_rs, cmd_rt, cmd_imm};
            default: enc_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pad_cnt_d = pad_cnt_q;
        err_d     = err_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    ptr_d     = '0;
                    pad_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (enc_valid) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (finish) begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                if (full) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (pad_cnt_q >= PAD_NOPS) begin
                    state_d = S_DONE;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = ptr_q[ADDR_W-1:0];
                    wdata_d   = 32'h0;
                    ptr_d     = ptr_q + 1'b1;
                    pad_cnt_d = pad_cnt_q + 32'd1;
                    // Leave on the last pad write so done rises without an idle cycle.
                    if (pad_cnt_q + 32'd1 >= PAD_NOPS) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            pad_cnt_q <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pad_cnt_q <= pad_cnt_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign cmd_ready  = (state_q == S_LOAD) & ~full;
    assign busy       = (state_q == S_LOAD) | (state_q == S_PAD);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign word_count = ptr_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - directed table-driven bench for inst_encoder_loader
module tb_inst_encoder_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-size instance
    logic        start, finish, cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        imem_we, busy, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  word_count;

    // Tiny instance for the full-memory corner
    logic        start2, finish2, cmd_valid2, cmd_ready2;
    logic [3:0]  cmd_op2;
    logic [4:0]  cmd_rd2;
    logic        imem_we2, busy2, done2, err2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  word_count2;

    inst_encoder_loader #(.ADDR_W(8), .PAD_NOPS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
        .word_count(word_count)
    );

    inst_encoder_loader #(.ADDR_W(2), .PAD_NOPS(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .finish(finish2),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op2),
        .cmd_rs(5'd1), .cmd_rt(5'd2), .cmd_rd(cmd_rd2), .cmd_imm(16'h0),
        .cmd_target(26'h0), .imem_we(imem_we2), .imem_addr(imem_addr2),
        .imem_wdata(imem_wdata2), .busy(busy2), .done(done2), .err(err2),
        .word_count(word_count2)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[13];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_rs     = rs;
        cmd_rt     = rt;
        cmd_rd     = rd;
        cmd_imm    = imm;
        cmd_target = tgt;
    endtask

    initial begin
        vecs[0]  = '{4'd1,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,      1'b1, 8'd0,  32'h00221820};
        vecs[1]  = '{4'd6,  5'd0,  5'd4,  5'd9,  16'h0010, 26'h0,      1'b1, 8'd1,  32'h8C040010};
        vecs[2]  = '{4'd7,  5'd0,  5'd5,  5'd0,  16'h0008, 26'h0,      1'b1, 8'd2,  32'hAC050008};
        vecs[3]  = '{4'd9,  5'd1,  5'd2,  5'd0,  16'hFFFE, 26'h0,      1'b1, 8'd3,  32'h1022FFFE};
        vecs[4]  = '{4'd8,  5'd7,  5'd7,  5'd7,  16'h1111, 26'h10,     1'b1, 8'd4,  32'h08000010};
        vecs[5]  = '{4'd2,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,      1'b1, 8'd5,  32'h00221822};
        vecs[6]  = '{4'd3,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,      1'b1, 8'd6,  32'h00221824};
        vecs[7]  = '{4'd4,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,      1'b1, 8'd7,  32'h00221825};
        vecs[8]  = '{4'd5,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,      1'b1, 8'd8,  32'h0022182A};
        vecs[9]  = '{4'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 8'd9,  32'h00000000};
        vecs[10] = '{4'd10, 5'd3,  5'd4,  5'd0,  16'h1234, 26'h0,      1'b1, 8'd10, 32'h14641234};
        vecs[11] = '{4'd13, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,      1'b0, 8'd0,  32'h0};
        vecs[12] = '{4'd1,  5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,      1'b1, 8'd11, 32'h03FFF820};

        rst = 1'b1; start = 0; finish = 0; cmd_valid = 0; cmd_op = 0; cmd_rs = 0;
        cmd_rt = 0; cmd_rd = 0; cmd_imm = 0; cmd_target = 0;
        start2 = 0; finish2 = 0; cmd_valid2 = 0; cmd_op2 = 0; cmd_rd2 = 0;
        tick(); tick();
        rst = 1'b0;

        check("reset imem_we", imem_we, 0);
        check("reset imem_wdata", imem_wdata, 0);
        check("reset cmd_ready", cmd_ready, 0);
        check("reset busy/done/err", {busy, done, err}, 0);
        check("reset word_count", word_count, 0);

        // Encoding table, one command per cycle
        start = 1; tick(); start = 0;
        check("after start busy", busy, 1);
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
            check($sformatf("vec%0d cmd_ready", i), cmd_ready, 1);
            tick();
            check($sformatf("vec%0d imem_we", i), imem_we, vecs[i].we);
            if (vecs[i].we) begin
                check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].addr);
                check($sformatf("vec%0d imem_wdata", i), imem_wdata, vecs[i].data);
            end
        end
        cmd_valid = 0;
        check("table err", err, 1);
        check("table word_count", word_count, 12);
        finish = 1; tick(); finish = 0;
        check("finish idle we", imem_we, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("table pad%0d we", k), imem_we, 1);
            check($sformatf("table pad%0d addr", k), imem_addr, 12 + k);
            check($sformatf("table pad%0d data", k), imem_wdata, 0);
        end
        check("table done", done, 1);
        check("table word_count final", word_count, 16);

        // Invalid op, then finish coinciding with an accepted command
        start = 1; tick(); start = 0;
        check("restart err cleared", err, 0);
        check("restart word_count", word_count, 0);
        drive(4'd13, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick();
        check("inv no write", imem_we, 0);
        check("inv err", err, 1);
        drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick();
        check("add after inv addr", imem_addr, 0);
        check("add after inv data", imem_wdata, 32'h00221820);
        drive(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick();
        check("sub addr", imem_addr, 1);
        drive(4'd6, 5'd0, 5'd4, 5'd0, 16'h0010, 26'h0); finish = 1; tick();
        finish = 0; cmd_valid = 0;
        check("lw with finish we", imem_we, 1);
        check("lw with finish addr", imem_addr, 2);
        check("lw with finish data", imem_wdata, 32'h8C040010);
        start = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            start = 0;
            check($sformatf("pad%0d we", k), imem_we, 1);
            check($sformatf("pad%0d addr", k), imem_addr, 3 + k);
            check($sformatf("pad%0d data", k), imem_wdata, 0);
        end
        check("pad done", done, 1);
        check("pad busy", busy, 0);
        check("pad word_count", word_count, 7);
        check("pad err sticky", err, 1);
        finish = 1; tick(); finish = 0;
        check("done no write", imem_we, 0);
        check("done held", done, 1);
        check("done word_count held", word_count, 7);

        // Reset in mid-LOAD cancels the pending write
        start = 1; tick(); start = 0;
        drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); tick();
        check("pre-rst we", imem_we, 1);
        drive(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0); rst = 1; tick();
        rst = 0; cmd_valid = 0;
        check("rst we", imem_we, 0);
        check("rst addr", imem_addr, 0);
        check("rst data", imem_wdata, 0);
        check("rst flags", {cmd_ready, busy, done, err}, 0);
        check("rst word_count", word_count, 0);

        // Full memory on the ADDR_W=2 instance
        start2 = 1; tick(); start2 = 0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid2 = 1; cmd_op2 = 4'd1; cmd_rd2 = 5'(k);
            tick();
            check($sformatf("full w%0d addr", k), imem_addr2, k);
        end
        check("full cmd_ready", cmd_ready2, 0);
        tick();
        check("full held no write", imem_we2, 0);
        check("full err clear", err2, 0);
        check("full word_count", word_count2, 4);
        finish2 = 1; tick(); finish2 = 0; cmd_valid2 = 0;
        check("full pad busy", busy2, 1);
        tick();
        check("full pad done", done2, 1);
        check("full pad err", err2, 1);
        check("full pad no write", imem_we2, 0);
        check("full pad word_count", word_count2, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
